regfile_port_sequencer: RTL and testbench



---
 rtl/regfile_port_sequencer.sv | 99 +++++++++
 tb/tb_regfile_port_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_sequencer.sv
// regfile_port_sequencer: serialises operand reads and writebacks onto one shared register-file port.
// Optional ZERO_REG_EN: register 0 reads as zero and ignores writes.
module regfile_port_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_rs1,
    input  logic [ADDR_W-1:0] rd_rs2,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [DATA_W-1:0] rd_op1,
    output logic [DATA_W-1:0] rd_op2,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_address,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out
);
    typedef enum logic [1:0] {IDLE, RD1, RD2, RSP} state_t;
    typedef enum logic {READ, WRITE} grant_t;

    state_t            state;
    grant_t            last_grant;
    logic [ADDR_W-1:0] rs1_q, rs2_q;
    logic              wr_grant, rd_grant;
    logic [DATA_W-1:0] rd_val;

    // On contention in IDLE the requester not served last time wins
    assign wr_grant = !reset && wr_valid &&
                      (state == RSP || (state == IDLE && (!rd_req_valid || last_grant == READ)));
    assign rd_grant = !reset && state == IDLE && rd_req_valid && (!wr_valid || last_grant == WRITE);
    assign wr_ready     = wr_grant;
    assign rd_req_ready = rd_grant;

`ifdef ZERO_REG_EN
    assign rf_write_enable = wr_grant && wr_addr != '0;
    assign rd_val          = rf_address == '0 ? '0 : rf_data_out;
`else
    assign rf_write_enable = wr_grant;
    assign rd_val          = rf_data_out;
`endif

    assign rf_address = wr_grant ? wr_addr : state == RD1 ? rs1_q : state == RD2 ? rs2_q : '0;
    assign rf_data_in = wr_grant ? wr_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= READ;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_op1       <= '0;
            rd_op2       <= '0;
            rd_rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_grant)
                        last_grant <= WRITE;
                    if (rd_grant) begin
                        last_grant <= READ;
                        rs1_q      <= rd_rs1;
                        rs2_q      <= rd_rs2;
                        state      <= RD1;
                    end
                end
                RD1: begin
                    rd_op1 <= rd_val;
                    if (rs1_q == rs2_q) begin
                        rd_op2       <= rd_val;
                        rd_rsp_valid <= 1'b1;
                        state        <= RSP;
                    end else begin
                        state <= RD2;
                    end
                end
                RD2: begin
                    rd_op2       <= rd_val;
                    rd_rsp_valid <= 1'b1;
                    state        <= RSP;
                end
                RSP: begin
                    if (rd_rsp_ready) begin
                        rd_rsp_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_port_sequencer.sv
// tb_regfile_port_sequencer: directed vectors plus randomized traffic against a shadow register model.
module tb_regfile_port_sequencer;
`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        rd_req_valid = 1'b0, rd_req_ready, rd_rsp_valid, rd_rsp_ready = 1'b1;
    logic [4:0]  rd_rs1 = '0, rd_rs2 = '0, wr_addr = '0, rf_address;
    logic [31:0] rd_op1, rd_op2, wr_data = '0, rf_data_in, rf_data_out;
    logic        wr_valid = 1'b0, wr_ready, rf_write_enable;

    int tests = 0, fails = 0;

    regfile_port_sequencer dut (
        .clk(clk), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rd_op1(rd_op1), .rd_op2(rd_op2),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rf_write_enable(rf_write_enable), .rf_address(rf_address),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;

    // The physical register file the sequencer drives
    logic [31:0] rf [32] = '{default: 32'h0};
    assign rf_data_out = rf[rf_address];
    always @(posedge clk) if (rf_write_enable) rf[rf_address] <= rf_data_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Shadow architectural state: what each register should hold, and operands owed to the consumer
    logic [31:0] mdl [32] = '{default: 32'h0};
    logic [63:0] exp_q [$];
    bit          we_r0;
    int          a7_hits;

    function automatic logic [31:0] rv(input logic [4:0] a);
        return (ZR && a == 5'd0) ? 32'h0 : mdl[a];
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            logic [63:0] e;
            check("excl_grant", 32'(wr_ready && rd_req_ready), 32'h0);
            if (rf_write_enable && rf_address == 5'd0) we_r0 = 1'b1;
            if (!rf_write_enable && rf_address == 5'd7) a7_hits++;
            if (wr_valid && wr_ready && !(ZR && wr_addr == 5'd0)) mdl[wr_addr] = wr_data;
            if (rd_req_valid && rd_req_ready) exp_q.push_back({rv(rd_rs1), rv(rd_rs2)});
            if (rd_rsp_valid && rd_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_rsp", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_op1", rd_op1, e[63:32]);
                    check("sb_op2", rd_op2, e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd_accept();
        bit ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = rd_req_ready;
            tick();
        end
        rd_req_valid = 1'b0;
        check("rd_accept", 32'(ok), 32'h1);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        bit ok = 1'b0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = wr_ready;
            tick();
        end
        wr_valid = 1'b0;
        check("wr_accept", 32'(ok), 32'h1);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b,
                           output logic [31:0] o1, output logic [31:0] o2, output int lat);
        bit ok = 1'b0;
        lat = 0;
        rd_req_valid = 1'b1; rd_rs1 = a; rd_rs2 = b; rd_rsp_ready = 1'b1;
        wait_rd_accept();
        for (int n = 1; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (rd_rsp_valid) begin ok = 1'b1; lat = n; end
            else tick();
        end
        check("rsp_seen", 32'(ok), 32'h1);
        o1 = rd_op1; o2 = rd_op2;
        tick();
    endtask

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1, r2;
        logic [31:0] e1, e2;
        int          lat;
    } vec_t;

    vec_t tbl [5];
    logic [1:0] arb_pat [8];

    initial begin
        logic [31:0] o1, o2;
        int lat;
        bit ok, wt, rt;
        tbl[0] = '{5'd5,  32'hDEADBEEF, 5'd5,  5'd6, 32'hDEADBEEF, 32'h0, 3};
        tbl[1] = '{5'd7,  32'h000000A5, 5'd7,  5'd7, 32'h000000A5, 32'h000000A5, 2};
        tbl[2] = '{5'd0,  32'h00001234, 5'd0,  5'd5, ZR ? 32'h0 : 32'h00001234, 32'hDEADBEEF, 3};
        tbl[3] = '{5'd31, 32'hFFFFFFFF, 5'd31, 5'd7, 32'hFFFFFFFF, 32'h000000A5, 3};
        tbl[4] = '{5'd6,  32'h00000001, 5'd6,  5'd5, 32'h00000001, 32'hDEADBEEF, 3};
        arb_pat = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b10};

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_rsp_valid", 32'(rd_rsp_valid), 32'h0);
        check("rst_op1", rd_op1, 32'h0);
        check("rst_op2", rd_op2, 32'h0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("idle_addr", 32'(rf_address), 32'h0);
        check("idle_we", 32'(rf_write_enable), 32'h0);
        tick();

        // Directed write-then-read vectors
        for (int i = 0; i < 5; i++) begin
            we_r0 = 1'b0; a7_hits = 0;
            do_write(tbl[i].wa, tbl[i].wd);
            do_read(tbl[i].r1, tbl[i].r2, o1, o2, lat);
            check($sformatf("vec%0d_op1", i), o1, tbl[i].e1);
            check($sformatf("vec%0d_op2", i), o2, tbl[i].e2);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            if (tbl[i].r1 == 5'd7 && tbl[i].r2 == 5'd7) check("r7_addr_once", 32'(a7_hits), 32'h1);
            if (tbl[i].wa == 5'd0) check("r0_write_enable", 32'(we_r0), 32'(!ZR));
        end

        // Arbitration after reset with both requesters held
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
        wr_valid = 1'b1; wr_addr = 5'd10; rd_req_valid = 1'b1; rd_rs1 = 5'd10; rd_rs2 = 5'd10;
        rd_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = $urandom;
            @(negedge clk);
            check($sformatf("arb%0d", i), 32'({wr_ready, rd_req_ready}), 32'(arb_pat[i]));
            tick();
        end
        wr_valid = 1'b0; rd_req_valid = 1'b0;
        repeat (4) tick();

        // Consumer stalls in RSP while a write to r9 goes through
        rd_rsp_ready = 1'b0; rd_req_valid = 1'b1; rd_rs1 = 5'd5; rd_rs2 = 5'd7;
        wait_rd_accept();
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = rd_rsp_valid;
            tick();
        end
        check("stall_rsp_seen", 32'(ok), 32'h1);
        wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h12345678;
        @(negedge clk);
        check("stall_wr_ready", 32'(wr_ready), 32'h1);
        check("stall_we", 32'(rf_write_enable), 32'h1);
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(rd_rsp_valid), 32'h1);
            check("stall_op1", rd_op1, 32'hDEADBEEF);
            check("stall_op2", rd_op2, 32'h000000A5);
            tick();
        end
        rd_rsp_ready = 1'b1;
        tick();
        do_read(5'd9, 5'd9, o1, o2, lat);
        check("r9_op1", o1, 32'h12345678);
        check("r9_op2", o2, 32'h12345678);

        // Reset while in RD2
        rd_req_valid = 1'b1; rd_rs1 = 5'd5; rd_rs2 = 5'd6;
        wait_rd_accept();
        tick();
        wr_valid = 1'b1; rd_req_valid = 1'b1; reset = 1'b1;
        #1;
        check("rst_mid_we", 32'(rf_write_enable), 32'h0);
        check("rst_mid_wr_ready", 32'(wr_ready), 32'h0);
        check("rst_mid_rd_ready", 32'(rd_req_ready), 32'h0);
        tick();
        reset = 1'b0; rd_req_valid = 1'b0; wr_addr = 5'd11; wr_data = 32'h55;
        check("rst_mid_rsp_valid", 32'(rd_rsp_valid), 32'h0);
        check("rst_mid_op1", rd_op1, 32'h0);
        check("rst_mid_op2", rd_op2, 32'h0);
        @(negedge clk);
        check("rst_mid_idle_grant", 32'(wr_ready), 32'h1);
        tick();
        wr_valid = 1'b0;
        tick();

        // Randomized traffic scored by the monitor
        wt = 1'b1; rt = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (!wr_valid || wt) begin
                wr_valid = ($urandom % 3) == 0; wr_addr = 5'($urandom); wr_data = $urandom;
            end
            if (!rd_req_valid || rt) begin
                rd_req_valid = ($urandom % 2) == 0;
                rd_rs1 = 5'($urandom_range(0, 7)); rd_rs2 = 5'($urandom_range(0, 7));
            end
            rd_rsp_ready = ($urandom % 4) != 0;
            @(negedge clk);
            wt = wr_ready; rt = rd_req_ready;
            tick();
        end
        wr_valid = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b1;
        repeat (6) tick();
        check("drain", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d failed so far", fails);
        $fatal(1);
    end
endmodule
